pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised next-generation program counter for the fetch stage. Holds the fetch PC and
//  auto-increments on accepted fetches. Adds stall/handshake, branch redirect, trap entry/return
//  with saved EPC, halt/resume, misalignment detection, and an optional return-address stack.
//  Sits between decode/execute redirect logic and the instruction memory request port.
// PARAMETERS
//  XLEN          32        PC width in bits
//  RESET_VECTOR  'h0       PC value loaded on reset
//  TRAP_VECTOR   'h100     PC loaded on trap entry
//  INSTR_BYTES   4         increment per accepted fetch; power of 2
//  RAS_DEPTH     4         return-address-stack entries (used only with PC_RAS_EN)
// PORTS
//  clk              in   1     clock; all state on rising edge
//  reset            in   1     async, active-high; clears all state
//  fetch_valid      out  1     pc is a valid fetch request
//  fetch_ready      in   1     imem accepts request this cycle
//  pc               out  XLEN  current fetch address
//  redirect_valid   in   1     branch/jump resolved taken
//  redirect_target  in   XLEN  new PC for redirect
//  trap_req         in   1     enter trap: EPC<=pc, pc<=TRAP_VECTOR
//  trap_ret         in   1     return from trap: pc<=EPC
//  halt_req         in   1     stop fetching after current cycle
//  resume           in   1     leave HALT
//  is_call          in   1     accepted fetch is a call (RAS push)
//  is_ret           in   1     accepted fetch is a return (RAS pop)
//  epc              out  XLEN  saved trap PC
//  misalign_err     out  1     1-cycle pulse: redirect target misaligned
// BEHAVIOUR
//  - Reset: pc=RESET_VECTOR, epc=0, fetch_valid=0, misalign_err=0, state=BOOT, RAS empty.
//  - States: BOOT -> RUN (one cycle after reset deassert); RUN -> HALT on halt_req;
//    HALT -> RUN on resume. fetch_valid=1 only in RUN.
//  - Next-PC priority per cycle: trap_req > trap_ret > redirect_valid > RAS pop > accept > hold.
//    accept = fetch_valid & fetch_ready -> pc <= pc+INSTR_BYTES (mod 2^XLEN, wraps silently).
//  - No accept (fetch_ready=0) and no event: pc holds; request must stay stable.
//  - redirect with target[log2(INSTR_BYTES)-1:0]!=0: redirect not taken; treated as trap
//    (epc<=target, pc<=TRAP_VECTOR), misalign_err pulses next cycle.
//  - trap_req/trap_ret/redirect act in BOOT, RUN and HALT; state unchanged except trap_req
//    in HALT forces RUN. halt_req and resume same cycle: resume wins in HALT, halt wins in RUN.
//  - Single-cycle latency: event in cycle N -> new pc visible cycle N+1.
//  - Reset asserted mid-operation overrides everything immediately (async).
// CONFIGURATION
//  PC_RAS_EN defined: RAS of RAS_DEPTH entries. Accepted fetch with is_call pushes
//    pc+INSTR_BYTES; accepted fetch with is_ret (no higher-priority event) sets pc<=top, pops.
//    Full push overwrites oldest (circular). Pop on empty: normal increment. Push+pop same
//    cycle: pop top then push. trap_req/redirect do not alter RAS.
//  PC_RAS_EN undefined: is_call/is_ret ignored; no RAS storage; RAS_DEPTH unused.
// STRUCTURE
//  Package pc_pkg: pc_state_e {BOOT,RUN,HALT}; next-pc select enum; INSTR_BYTES alignment
//  mask helper. Sub-module pc_ras (circular stack: push/pop/top/empty) instantiated only
//  under PC_RAS_EN.
// TESTING
//  1 reset, release; ready=1 -> pc 0x0 (valid=0), then 0x0,0x4,0x8 with valid=1.
//  2 ready=0 for 3 cycles at pc=0x8 -> pc holds 0x8; ready=1 -> 0xC.
//  3 redirect 0x40 with trap_req same cycle -> pc=0x100, epc=old pc; trap_ret -> pc=epc.
//  4 redirect 0x42 -> pc=0x100, epc=0x42, misalign_err one-cycle pulse.
//  5 halt_req at pc=0x20 -> valid=0, pc frozen; resume -> valid=1, pc continues 0x20.
//  6 PC_RAS_EN: call at 0x10, call at 0x80, ret, ret -> targets 0x84 then 0x14;
//    5 calls with DEPTH=4 then 5 rets -> 4 stacked targets then sequential increment.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared state/select types and alignment helper for the
// fetch-stage PC sequencer.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } pc_state_e;

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_ACCEPT,
      SEL_POP,
      SEL_REDIR,
      SEL_MISAL,
      SEL_TRET,
      SEL_TRAP
   } pc_sel_e;

   // Low-order PC bits that must be zero for an aligned fetch.
   function automatic int unsigned align_mask(
      input int unsigned bytes
   );
      return bytes - 32'd1;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch request and control bundle between the PC
// sequencer (master) and surrounding fetch/decode logic (slave).
interface pc_sequencer_if #(
   parameter int XLEN = 32
);

   logic            fetch_valid;
   logic            fetch_ready;
   logic [XLEN-1:0] pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            trap_req;
   logic            trap_ret;
   logic            halt_req;
   logic            resume;
   logic            is_call;
   logic            is_ret;
   logic [XLEN-1:0] epc;
   logic            misalign_err;

   modport master (
      output fetch_valid,
      output pc,
      output epc,
      output misalign_err,
      input  fetch_ready,
      input  redirect_valid,
      input  redirect_target,
      input  trap_req,
      input  trap_ret,
      input  halt_req,
      input  resume,
      input  is_call,
      input  is_ret
   );

   modport slave (
      input  fetch_valid,
      input  pc,
      input  epc,
      input  misalign_err,
      output fetch_ready,
      output redirect_valid,
      output redirect_target,
      output trap_req,
      output trap_ret,
      output halt_req,
      output resume,
      output is_call,
      output is_ret
   );

endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites
// the oldest entry, push+pop in one cycle replaces the top.
module pc_ras #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] din,
   output logic [XLEN-1:0] top,
   output logic            empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [XLEN-1:0] mem [DEPTH];
   logic [AW-1:0]   ptr;
   logic [AW-1:0]   ptr_inc;
   logic [AW-1:0]   top_idx;
   logic [AW-1:0]   wr_idx;
   logic [CW-1:0]   cnt;
   logic            full;
   logic            do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign ptr_inc = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
   assign top_idx = (ptr == '0) ? AW'(DEPTH - 1) : ptr - AW'(1);
   assign top     = mem[top_idx];

   // Pop-then-push collapses to overwriting the current top slot.
   assign wr_idx = do_pop ? top_idx : ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_idx] <= din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
         cnt <= '0;
      end else if (push && !do_pop) begin
         ptr <= ptr_inc;
         if (!full) begin
            cnt <= cnt + CW'(1);
         end
      end else if (do_pop && !push) begin
         ptr <= top_idx;
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC with redirect, trap, halt and misalign
// handling. Define PC_RAS_EN to add the return-address stack.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
   parameter int              INSTR_BYTES  = 4,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.master bus
);

   pc_state_e       state;
   pc_state_e       state_nx;
   pc_sel_e         sel;
   logic            fetch_valid;
   logic            accept;
   logic            misal;
   logic            misal_q;
   logic            ras_hit;
   logic [XLEN-1:0] ras_top;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] epc_q;
   logic [XLEN-1:0] pc_inc;

   assign pc_inc = pc_q + XLEN'(INSTR_BYTES);
   assign accept = fetch_valid & bus.fetch_ready;
   assign misal  = |(bus.redirect_target &
                     XLEN'(align_mask(INSTR_BYTES)));

`ifdef PC_RAS_EN
   logic ras_push;
   logic ras_pop;
   logic ras_empty;

   assign ras_hit  = accept & bus.is_ret & ~ras_empty;
   assign ras_pop  = (sel == SEL_POP);
   // Calls only push when the fetch actually advances the stream.
   assign ras_push = bus.is_call &
                     ((sel == SEL_POP) | (sel == SEL_ACCEPT));

   pc_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (pc_inc),
      .top   (ras_top),
      .empty (ras_empty)
   );
`else
   localparam int UNUSED_DEPTH = RAS_DEPTH;
   logic unused_ras;

   assign unused_ras = bus.is_call ^ bus.is_ret;
   assign ras_hit    = 1'b0;
   assign ras_top    = '0;
`endif

   always_comb begin
      sel = SEL_HOLD;
      if (bus.trap_req) begin
         sel = SEL_TRAP;
      end else if (bus.trap_ret) begin
         sel = SEL_TRET;
      end else if (bus.redirect_valid) begin
         sel = misal ? SEL_MISAL : SEL_REDIR;
      end else if (ras_hit) begin
         sel = SEL_POP;
      end else if (accept) begin
         sel = SEL_ACCEPT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         BOOT: state_nx = RUN;
         RUN: begin
            if (bus.halt_req) begin
               state_nx = HALT;
            end
         end
         HALT: begin
            if (bus.resume || bus.trap_req) begin
               state_nx = RUN;
            end
         end
         default: state_nx = BOOT;
      endcase
   end

   always_comb begin
      fetch_valid = (state == RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_VECTOR;
         epc_q   <= '0;
         misal_q <= 1'b0;
      end else begin
         misal_q <= (sel == SEL_MISAL);
         unique case (sel)
            SEL_TRAP: begin
               epc_q <= pc_q;
               pc_q  <= TRAP_VECTOR;
            end
            SEL_TRET:   pc_q <= epc_q;
            SEL_REDIR:  pc_q <= bus.redirect_target;
            // Bad target is reported through epc.
            SEL_MISAL: begin
               epc_q <= bus.redirect_target;
               pc_q  <= TRAP_VECTOR;
            end
            SEL_POP:    pc_q <= ras_top;
            SEL_ACCEPT: pc_q <= pc_inc;
            default: ;
         endcase
      end
   end

   assign bus.fetch_valid  = fetch_valid;
   assign bus.pc           = pc_q;
   assign bus.epc          = epc_q;
   assign bus.misalign_err = misal_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer; the return
// stack scenario is compiled in when PC_RAS_EN is defined.
module tb_pc_sequencer;

   localparam logic [7:0] F_NONE = 8'h00;
   localparam logic [7:0] F_RDY  = 8'h80;
   localparam logic [7:0] F_RV   = 8'h40;
   localparam logic [7:0] F_TRAP = 8'h20;
   localparam logic [7:0] F_TRET = 8'h10;
   localparam logic [7:0] F_HLT  = 8'h08;
   localparam logic [7:0] F_RES  = 8'h04;
   localparam logic [7:0] F_CALL = 8'h02;
   localparam logic [7:0] F_RET  = 8'h01;

   typedef struct packed {
      logic        v;
      logic        m;
      logic [31:0] pc;
      logic [31:0] epc;
   } obs_t;

   typedef struct packed {
      logic [7:0]  f;
      logic [31:0] tgt;
      obs_t        exp;
   } step_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   obs_t sb[$];
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   pc_sequencer_if #(.XLEN(32)) bus ();

   pc_sequencer #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0),
      .TRAP_VECTOR  (32'h100),
      .INSTR_BYTES  (4),
      .RAS_DEPTH    (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic step_t mk(
      logic [7:0] f, logic [31:0] tgt, logic v,
      logic m, logic [31:0] pc, logic [31:0] epc
   );
      step_t s;
      s.f       = f;
      s.tgt     = tgt;
      s.exp.v   = v;
      s.exp.m   = m;
      s.exp.pc  = pc;
      s.exp.epc = epc;
      return s;
   endfunction

   function automatic obs_t obs();
      obs_t o;
      o.v   = bus.fetch_valid;
      o.m   = bus.misalign_err;
      o.pc  = bus.pc;
      o.epc = bus.epc;
      return o;
   endfunction

   task automatic drive(step_t s);
      bus.fetch_ready     = s.f[7];
      bus.redirect_valid  = s.f[6];
      bus.redirect_target = s.tgt;
      bus.trap_req        = s.f[5];
      bus.trap_ret        = s.f[4];
      bus.halt_req        = s.f[3];
      bus.resume          = s.f[2];
      bus.is_call         = s.f[1];
      bus.is_ret          = s.f[0];
   endtask

   task automatic test_reset();
      obs_t e, o;
      drive(mk(F_NONE, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0));
      reset = 1'b1;
      sb.push_back(mk(F_NONE, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0).exp);
      @(negedge clk);
      e = sb.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL reset: got %h want %h", o, e);
      end
      reset = 1'b0;
      bus.fetch_ready = 1'b1;
      sb.push_back(mk(F_NONE, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0).exp);
      #1;
      e = sb.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL boot: got %h want %h", o, e);
      end
   endtask

   task automatic test_sequential();
      step_t s[$];
      obs_t e, o;
      s.push_back(mk(F_RDY, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0));
      s.push_back(mk(F_RDY, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0));
      s.push_back(mk(F_RDY, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0));
      foreach (s[i]) begin
         drive(s[i]);
         sb.push_back(s[i].exp);
         @(negedge clk);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL seq[%0d]: got v=%b m=%b pc=%h epc=%h want v=%b m=%b pc=%h epc=%h",
                     i, o.v, o.m, o.pc, o.epc, e.v, e.m, e.pc, e.epc);
         end
      end
   endtask

   task automatic test_stall();
      step_t s[$];
      obs_t e, o;
      for (int k = 0; k < 3; k++) begin
         s.push_back(mk(F_NONE, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0));
      end
      s.push_back(mk(F_RDY, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0));
      foreach (s[i]) begin
         drive(s[i]);
         sb.push_back(s[i].exp);
         @(negedge clk);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL stall[%0d]: got v=%b m=%b pc=%h epc=%h want v=%b m=%b pc=%h epc=%h",
                     i, o.v, o.m, o.pc, o.epc, e.v, e.m, e.pc, e.epc);
         end
      end
   endtask

   task automatic test_trap();
      step_t s[$];
      obs_t e, o;
      s.push_back(mk(F_RDY | F_TRAP | F_RV, 32'h40,
                     1'b1, 1'b0, 32'h100, 32'hC));
      s.push_back(mk(F_RDY | F_TRET | F_RV, 32'h60,
                     1'b1, 1'b0, 32'hC, 32'hC));
      s.push_back(mk(F_RDY | F_RV, 32'h40,
                     1'b1, 1'b0, 32'h40, 32'hC));
      s.push_back(mk(F_RDY, 32'h0, 1'b1, 1'b0, 32'h44, 32'hC));
      foreach (s[i]) begin
         drive(s[i]);
         sb.push_back(s[i].exp);
         @(negedge clk);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL trap[%0d]: got v=%b m=%b pc=%h epc=%h want v=%b m=%b pc=%h epc=%h",
                     i, o.v, o.m, o.pc, o.epc, e.v, e.m, e.pc, e.epc);
         end
      end
   endtask

   task automatic test_misalign();
      step_t s[$];
      obs_t e, o;
      s.push_back(mk(F_RDY | F_RV, 32'h42,
                     1'b1, 1'b1, 32'h100, 32'h42));
      s.push_back(mk(F_NONE, 32'h0, 1'b1, 1'b0, 32'h100, 32'h42));
      s.push_back(mk(F_RDY | F_RV, 32'h41,
                     1'b1, 1'b1, 32'h100, 32'h41));
      s.push_back(mk(F_RDY, 32'h0, 1'b1, 1'b0, 32'h104, 32'h41));
      s.push_back(mk(F_RDY | F_TRAP | F_RV, 32'h43,
                     1'b1, 1'b0, 32'h100, 32'h104));
      foreach (s[i]) begin
         drive(s[i]);
         sb.push_back(s[i].exp);
         @(negedge clk);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL misalign[%0d]: got v=%b m=%b pc=%h epc=%h want v=%b m=%b pc=%h epc=%h",
                     i, o.v, o.m, o.pc, o.epc, e.v, e.m, e.pc, e.epc);
         end
      end
   endtask

   task automatic test_wrap();
      step_t s[$];
      obs_t e, o;
      s.push_back(mk(F_RDY | F_RV, 32'hFFFF_FFFC,
                     1'b1, 1'b0, 32'hFFFF_FFFC, 32'h104));
      s.push_back(mk(F_RDY, 32'h0, 1'b1, 1'b0, 32'h0, 32'h104));
      s.push_back(mk(F_RDY, 32'h0, 1'b1, 1'b0, 32'h4, 32'h104));
      foreach (s[i]) begin
         drive(s[i]);
         sb.push_back(s[i].exp);
         @(negedge clk);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL wrap[%0d]: got v=%b m=%b pc=%h epc=%h want v=%b m=%b pc=%h epc=%h",
                     i, o.v, o.m, o.pc, o.epc, e.v, e.m, e.pc, e.epc);
         end
      end
   endtask

   task automatic test_halt();
      step_t s[$];
      obs_t e, o;
      s.push_back(mk(F_RDY | F_RV, 32'h1C,
                     1'b1, 1'b0, 32'h1C, 32'h104));
      s.push_back(mk(F_RDY | F_HLT, 32'h0,
                     1'b0, 1'b0, 32'h20, 32'h104));
      s.push_back(mk(F_RDY, 32'h0, 1'b0, 1'b0, 32'h20, 32'h104));
      s.push_back(mk(F_RDY, 32'h0, 1'b0, 1'b0, 32'h20, 32'h104));
      s.push_back(mk(F_RDY | F_HLT | F_RES, 32'h0,
                     1'b1, 1'b0, 32'h20, 32'h104));
      s.push_back(mk(F_RDY, 32'h0, 1'b1, 1'b0, 32'h24, 32'h104));
      s.push_back(mk(F_HLT | F_RES, 32'h0,
                     1'b0, 1'b0, 32'h24, 32'h104));
      s.push_back(mk(F_RDY | F_RV, 32'h300,
                     1'b0, 1'b0, 32'h300, 32'h104));
      s.push_back(mk(F_RDY | F_TRAP, 32'h0,
                     1'b1, 1'b0, 32'h100, 32'h300));
      s.push_back(mk(F_RDY | F_TRET, 32'h0,
                     1'b1, 1'b0, 32'h300, 32'h300));
      foreach (s[i]) begin
         drive(s[i]);
         sb.push_back(s[i].exp);
         @(negedge clk);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL halt[%0d]: got v=%b m=%b pc=%h epc=%h want v=%b m=%b pc=%h epc=%h",
                     i, o.v, o.m, o.pc, o.epc, e.v, e.m, e.pc, e.epc);
         end
      end
   endtask

`ifdef PC_RAS_EN
   task automatic test_ras();
      step_t s[$];
      obs_t e, o;
      s.push_back(mk(F_RDY | F_RV, 32'h10, 1'b1, 1'b0, 32'h10, 32'h300));
      s.push_back(mk(F_RDY | F_CALL, 32'h0, 1'b1, 1'b0, 32'h14, 32'h300));
      s.push_back(mk(F_RDY | F_RV, 32'h80, 1'b1, 1'b0, 32'h80, 32'h300));
      s.push_back(mk(F_RDY | F_CALL, 32'h0, 1'b1, 1'b0, 32'h84, 32'h300));
      s.push_back(mk(F_RDY | F_RV, 32'h200, 1'b1, 1'b0, 32'h200, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h84, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h14, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h18, 32'h300));
      s.push_back(mk(F_RDY | F_RV, 32'h400, 1'b1, 1'b0, 32'h400, 32'h300));
      for (int k = 0; k < 5; k++) begin
         s.push_back(mk(F_RDY | F_CALL, 32'h0, 1'b1, 1'b0,
                        32'h404 + 32'(4 * k), 32'h300));
      end
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h414, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h410, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h40C, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h408, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h40C, 32'h300));
      s.push_back(mk(F_RDY | F_CALL, 32'h0, 1'b1, 1'b0, 32'h410, 32'h300));
      s.push_back(mk(F_RDY | F_CALL | F_RET, 32'h0,
                     1'b1, 1'b0, 32'h410, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h414, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h418, 32'h300));
      s.push_back(mk(F_RDY | F_CALL, 32'h0, 1'b1, 1'b0, 32'h41C, 32'h300));
      s.push_back(mk(F_RDY | F_RV | F_RET, 32'h500,
                     1'b1, 1'b0, 32'h500, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h41C, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h420, 32'h300));
      foreach (s[i]) begin
         drive(s[i]);
         sb.push_back(s[i].exp);
         @(negedge clk);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL ras[%0d]: got v=%b m=%b pc=%h epc=%h want v=%b m=%b pc=%h epc=%h",
                     i, o.v, o.m, o.pc, o.epc, e.v, e.m, e.pc, e.epc);
         end
      end
   endtask
`else
   task automatic test_ras_ignored();
      step_t s[$];
      obs_t e, o;
      s.push_back(mk(F_RDY | F_CALL, 32'h0, 1'b1, 1'b0, 32'h304, 32'h300));
      s.push_back(mk(F_RDY | F_RET, 32'h0, 1'b1, 1'b0, 32'h308, 32'h300));
      s.push_back(mk(F_RDY | F_CALL | F_RET, 32'h0,
                     1'b1, 1'b0, 32'h30C, 32'h300));
      foreach (s[i]) begin
         drive(s[i]);
         sb.push_back(s[i].exp);
         @(negedge clk);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL noras[%0d]: got v=%b m=%b pc=%h epc=%h want v=%b m=%b pc=%h epc=%h",
                     i, o.v, o.m, o.pc, o.epc, e.v, e.m, e.pc, e.epc);
         end
      end
   endtask
`endif

   task automatic test_async_reset();
      obs_t e, o;
      reset = 1'b1;
      sb.push_back(mk(F_NONE, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0).exp);
      #1;
      e = sb.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL async_reset: got %h want %h", o, e);
      end
      drive(mk(F_RDY, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0));
      sb.push_back(mk(F_NONE, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0).exp);
      @(negedge clk);
      e = sb.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL reset_hold: got %h want %h", o, e);
      end
      reset = 1'b0;
      sb.push_back(mk(F_NONE, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0).exp);
      sb.push_back(mk(F_NONE, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0).exp);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL restart[%0d]: got %h want %h", k, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_trap();
      test_misalign();
      test_wrap();
      test_halt();
`ifdef PC_RAS_EN
      test_ras();
`else
      test_ras_ignored();
`endif
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
